endstop_conditioner: RTL and testbench

//  Conditions raw endstop pins before the command block consumes them.
//  Per channel: 2-FF synchronise, optional invert, debounce, edge event with sticky pending/overrun.

---
 rtl/conan_pkg.sv | 13 +
 rtl/endstop_channel.sv | 109 ++++++++++
 rtl/endstop_conditioner.sv | 45 ++++
 tb/tb_endstop_conditioner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conan_pkg.sv
// Shared constants and the command-side event view for the endstop conditioner.
package conan_pkg;

  localparam int ENDSTOP_DEB_BITS = 16;
  localparam int ENDSTOP_TS_BITS  = 32;

  typedef struct packed {
    logic state;
    logic pending;
    logic overrun;
  } endstop_evt_t;

endpackage

// File: rtl/endstop_channel.sv
// One endstop channel: synchroniser, polarity, debounce, sticky event flags and edge timestamp.
// The timestamp register exists only when ENDSTOP_TIMESTAMP_EN is defined.
module endstop_channel
  import conan_pkg::*;
#(
  parameter int DEB_BITS = ENDSTOP_DEB_BITS,
  parameter int TS_BITS  = ENDSTOP_TS_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pin,
  input  logic [TS_BITS-1:0]  systime_lo,
  input  logic [DEB_BITS-1:0] cfg_debounce,
  input  logic                invert,
  input  logic                ack,
  output logic                state,
  output logic                pending,
  output logic                overrun,
  output logic [TS_BITS-1:0]  edge_ts
);

  logic                s1_q, s1_d;
  logic                s2_q, s2_d;
  logic [DEB_BITS-1:0] cnt_q, cnt_d;
  endstop_evt_t        evt_q, evt_d;
  logic                lvl_s;
  logic                fire_s;

  // Synchroniser, debounce counter and event flag next-state logic
  always_comb begin
    s1_d   = pin;
    s2_d   = s1_q;
    lvl_s  = s2_q ^ invert;
    cnt_d  = cnt_q;
    fire_s = 1'b0;
    evt_d  = evt_q;

    if (lvl_s == evt_q.state) begin
      cnt_d = '0;
    end else if (cnt_q >= cfg_debounce) begin
      cnt_d  = '0;
      fire_s = 1'b1;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + DEB_BITS'(1);
    end

    // An event beats a coincident ack so an edge is never dropped silently
    if (fire_s) begin
      evt_d.state   = lvl_s;
      evt_d.pending = 1'b1;
      evt_d.overrun = evt_q.overrun | evt_q.pending;
    end else if (ack) begin
      evt_d.pending = 1'b0;
      evt_d.overrun = 1'b0;
    end else begin
      evt_d = evt_q;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      cnt_q <= '0;
      evt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      cnt_q <= cnt_d;
      evt_q <= evt_d;
    end
  end

  assign state   = evt_q.state;
  assign pending = evt_q.pending;
  assign overrun = evt_q.overrun;

`ifdef ENDSTOP_TIMESTAMP_EN
  logic [TS_BITS-1:0] ts_q, ts_d;

  // Keep the time of the first unacknowledged edge
  always_comb begin
    if (fire_s && (!evt_q.pending || ack)) begin
      ts_d = systime_lo;
    end else begin
      ts_d = ts_q;
    end
  end

  // Timestamp register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign edge_ts = ts_q;
`else
  logic unused_ts_s;
  assign unused_ts_s = ^systime_lo;
  assign edge_ts     = '0;
`endif

endmodule

// File: rtl/endstop_conditioner.sv
// Conditions NENDSTOP raw endstop pins for the command block; one endstop_channel per pin.
// Edge timestamps are captured only when ENDSTOP_TIMESTAMP_EN is defined, otherwise edge_ts is 0.
module endstop_conditioner
  import conan_pkg::*;
#(
  parameter int NENDSTOP = 8,
  parameter int DEB_BITS = ENDSTOP_DEB_BITS,
  parameter int TS_BITS  = ENDSTOP_TS_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NENDSTOP-1:0]         endstop_in,
  input  logic [63:0]                 systime,
  input  logic [DEB_BITS-1:0]         cfg_debounce,
  input  logic [NENDSTOP-1:0]         cfg_invert,
  input  logic [NENDSTOP-1:0]         ack,
  output logic [NENDSTOP-1:0]         state,
  output logic [NENDSTOP-1:0]         pending,
  output logic [NENDSTOP-1:0]         overrun,
  output logic [NENDSTOP*TS_BITS-1:0] edge_ts
);

  logic unused_systime_hi_s;
  assign unused_systime_hi_s = ^systime[63:TS_BITS];

  for (genvar i = 0; i < NENDSTOP; i++) begin : g_ch
    endstop_channel #(
      .DEB_BITS (DEB_BITS),
      .TS_BITS  (TS_BITS)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .pin          (endstop_in[i]),
      .systime_lo   (systime[TS_BITS-1:0]),
      .cfg_debounce (cfg_debounce),
      .invert       (cfg_invert[i]),
      .ack          (ack[i]),
      .state        (state[i]),
      .pending      (pending[i]),
      .overrun      (overrun[i]),
      .edge_ts      (edge_ts[i*TS_BITS +: TS_BITS])
    );
  end

endmodule

// File: tb/tb_endstop_conditioner.sv
// Self-checking bench for endstop_conditioner: vector table, corner sequences, random run vs model.
module tb_endstop_conditioner;
  import conan_pkg::*;

  localparam int N  = 8;
  localparam int DB = ENDSTOP_DEB_BITS;
  localparam int TB = ENDSTOP_TS_BITS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    endstop_in;
  logic [63:0]     systime;
  logic [DB-1:0]   cfg_debounce;
  logic [N-1:0]    cfg_invert;
  logic [N-1:0]    ack;
  logic [N-1:0]    state;
  logic [N-1:0]    pending;
  logic [N-1:0]    overrun;
  logic [N*TB-1:0] edge_ts;

  endstop_conditioner #(.NENDSTOP(N), .DEB_BITS(DB), .TS_BITS(TB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .endstop_in   (endstop_in),
    .systime      (systime),
    .cfg_debounce (cfg_debounce),
    .cfg_invert   (cfg_invert),
    .ack          (ack),
    .state        (state),
    .pending      (pending),
    .overrun      (overrun),
    .edge_ts      (edge_ts)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pin history, per-channel run length of disagreement, sticky flags
  logic [N-1:0]  m_hist[$];
  logic [N-1:0]  m_state, m_pend, m_ovr;
  int            m_run[N];
  logic [TB-1:0] m_ts[N];

  task automatic chk(input string name, input logic [N*TB-1:0] act, input logic [N*TB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back('0);
    m_hist.push_back('0);
    m_state = '0;
    m_pend  = '0;
    m_ovr   = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_ts[i]  = '0;
    end
  endtask

  // Applies the rules for the coming clock edge using the inputs currently driven
  task automatic model_edge();
    logic [N-1:0] lvl;
    logic [N-1:0] pend_old;
    bit ev;
    lvl      = m_hist[1] ^ cfg_invert;
    pend_old = m_pend;
    for (int i = 0; i < N; i++) begin
      ev = 1'b0;
      if (lvl[i] == m_state[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] >= int'(cfg_debounce)) begin
        m_state[i] = lvl[i];
        m_run[i]   = 0;
        ev         = 1'b1;
      end else if (m_run[i] < 65535) begin
        m_run[i]++;
      end
      if (ev) begin
        if (!pend_old[i] || ack[i]) m_ts[i] = systime[TB-1:0];
        m_ovr[i]  = m_ovr[i] | pend_old[i];
        m_pend[i] = 1'b1;
      end else if (ack[i]) begin
        m_pend[i] = 1'b0;
        m_ovr[i]  = 1'b0;
      end
    end
    m_hist.push_front(endstop_in);
    void'(m_hist.pop_back());
  endtask

  task automatic check_all();
    logic [N*TB-1:0] exp_ts;
    exp_ts = '0;
`ifdef ENDSTOP_TIMESTAMP_EN
    for (int i = 0; i < N; i++) exp_ts[i*TB +: TB] = m_ts[i];
`endif
    chk("state",   {{(N*TB-N){1'b0}}, state},   {{(N*TB-N){1'b0}}, m_state});
    chk("pending", {{(N*TB-N){1'b0}}, pending}, {{(N*TB-N){1'b0}}, m_pend});
    chk("overrun", {{(N*TB-N){1'b0}}, overrun}, {{(N*TB-N){1'b0}}, m_ovr});
    chk("edge_ts", edge_ts, exp_ts);
  endtask

  // Called 1 time unit after an active edge; returns 1 time unit after the next one
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    systime = systime + 64'd1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    chk(name, {{(N*TB-1){1'b0}}, act}, {{(N*TB-1){1'b0}}, exp});
  endtask

  typedef struct {
    logic [N-1:0] pin;
    logic [N-1:0] inv;
    logic [N-1:0] ack;
    int           hold;
    logic [N-1:0] st;
    logic [N-1:0] pd;
    logic [N-1:0] ov;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [TB-1:0] t0;
    logic [TB-1:0] ts0;

    // Debounce 0: every entry settles within its hold time
    vt[0] = '{8'h00, 8'h00, 8'h00, 4, 8'h00, 8'h00, 8'h00};
    vt[1] = '{8'h05, 8'h00, 8'h00, 4, 8'h05, 8'h05, 8'h00};
    vt[2] = '{8'h05, 8'h00, 8'h01, 1, 8'h05, 8'h04, 8'h00};
    vt[3] = '{8'h00, 8'h00, 8'h00, 4, 8'h00, 8'h05, 8'h04};
    vt[4] = '{8'h00, 8'h00, 8'hFF, 1, 8'h00, 8'h00, 8'h00};
    vt[5] = '{8'h00, 8'h81, 8'h00, 4, 8'h81, 8'h81, 8'h00};
    vt[6] = '{8'h80, 8'h81, 8'h81, 1, 8'h81, 8'h00, 8'h00};
    vt[7] = '{8'h80, 8'h81, 8'h00, 4, 8'h01, 8'h80, 8'h00};

    endstop_in   = '0;
    cfg_invert   = '0;
    cfg_debounce = '0;
    ack          = '0;
    systime      = 64'd0;
    #1;
    do_reset();

    for (int v = 0; v < 8; v++) begin
      endstop_in = vt[v].pin;
      cfg_invert = vt[v].inv;
      ack        = vt[v].ack;
      for (int h = 0; h < vt[v].hold; h++) begin
        tick();
        ack = '0;
      end
      chk($sformatf("vec%0d_state", v),   {{(N*TB-N){1'b0}}, state},   {{(N*TB-N){1'b0}}, vt[v].st});
      chk($sformatf("vec%0d_pending", v), {{(N*TB-N){1'b0}}, pending}, {{(N*TB-N){1'b0}}, vt[v].pd});
      chk($sformatf("vec%0d_overrun", v), {{(N*TB-N){1'b0}}, overrun}, {{(N*TB-N){1'b0}}, vt[v].ov});
    end

    // Latency with debounce 0: three edges from pin change to state
    cfg_invert = '0;
    endstop_in = '0;
    do_reset();
    repeat (9) tick();
    endstop_in[0] = 1'b1;
    tick();
    tick();
    chk_bit("lat_state_early", state[0], 1'b0);
    tick();
    chk_bit("lat_state", state[0], 1'b1);
    chk_bit("lat_pending", pending[0], 1'b1);

    // Glitch rejection and accepted pulse with debounce 5
    cfg_debounce = 16'd5;
    endstop_in[2] = 1'b1;
    repeat (4) tick();
    endstop_in[2] = 1'b0;
    repeat (12) tick();
    chk_bit("glitch_state", state[2], 1'b0);
    chk_bit("glitch_pending", pending[2], 1'b0);
    endstop_in[2] = 1'b1;
    repeat (7) tick();
    endstop_in[2] = 1'b0;
    chk_bit("pulse_state_early", state[2], 1'b0);
    tick();
    chk_bit("pulse_state_rise", state[2], 1'b1);
    repeat (10) tick();
    chk_bit("pulse_state_fall", state[2], 1'b0);
    chk_bit("pulse_overrun", overrun[2], 1'b1);

    // Event coinciding with ack keeps pending and records the earlier pending as overrun
    cfg_debounce = '0;
    ack = '1;
    tick();
    ack = '0;
    endstop_in[1] = 1'b1;
    repeat (3) tick();
    chk_bit("ackev_pre_pending", pending[1], 1'b1);
    endstop_in[1] = 1'b0;
    tick();
    tick();
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0;
    chk_bit("ackev_pending", pending[1], 1'b1);
    chk_bit("ackev_overrun", overrun[1], 1'b1);
    ack[1] = 1'b1;
    tick();
    ack[1] = 1'b0;
    chk_bit("ack_pending", pending[1], 1'b0);
    chk_bit("ack_overrun", overrun[1], 1'b0);

    // Inverted channel held low through reset
    endstop_in = '0;
    cfg_invert = 8'h01;
    do_reset();
    repeat (3) tick();
    chk_bit("inv_state", state[0], 1'b1);
    chk_bit("inv_pending", pending[0], 1'b1);

    // Timestamp of the first unacknowledged edge
    cfg_invert = '0;
    do_reset();
    systime = 64'h1000;
    t0 = systime[TB-1:0];
    endstop_in[0] = 1'b1;
    repeat (3) tick();
`ifdef ENDSTOP_TIMESTAMP_EN
    // Accepted on the third edge; systime advances once per edge
    ts0 = t0 + 32'd2;
`else
    ts0 = '0;
`endif
    chk("ts_first", {{(N*TB-TB){1'b0}}, edge_ts[TB-1:0]}, {{(N*TB-TB){1'b0}}, ts0});
    systime = 64'h2000;
    endstop_in[0] = 1'b0;
    repeat (3) tick();
    chk("ts_kept", {{(N*TB-TB){1'b0}}, edge_ts[TB-1:0]}, {{(N*TB-TB){1'b0}}, ts0});
    chk_bit("ts_overrun", overrun[0], 1'b1);

    // Reset mid-count with a pending event, then a clean restart
    cfg_debounce = 16'd5;
    endstop_in[2] = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_state",   {{(N*TB-N){1'b0}}, state},   '0);
    chk("rst_pending", {{(N*TB-N){1'b0}}, pending}, '0);
    chk("rst_overrun", {{(N*TB-N){1'b0}}, overrun}, '0);
    chk("rst_edge_ts", edge_ts, '0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (7) tick();
    chk_bit("restart_state_early", state[2], 1'b0);
    tick();
    chk_bit("restart_state", state[2], 1'b1);
    chk_bit("restart_pending", pending[2], 1'b1);
    chk_bit("restart_overrun", overrun[2], 1'b0);

    // Randomised run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) endstop_in[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 199) == 0) cfg_debounce = DB'($urandom_range(0, 6));
      if ($urandom_range(0, 299) == 0) cfg_invert = N'($urandom);
      if ($urandom_range(0, 63) == 0) systime = {32'd0, $urandom};
      ack = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
